// File: rtl/fft_peak_detect.sv
// Per-frame peak finder for a 16-bin FFT stream: reports the strongest bin, its
// magnitude squared and the frame energy, with a one-deep result register and backpressure.
module fft_peak_detect #(
  parameter int FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_push,
  input  logic [15:0] in_real,
  input  logic [15:0] in_imag,
  output logic        in_stall,
  output logic        out_push,
  output logic [3:0]  out_bin,
  output logic [31:0] out_mag,
  output logic [35:0] out_energy,
  input  logic        out_stall
);

  localparam logic [3:0] LAST_BIN = 4'(FRAME_LEN - 1);

  logic [3:0]         bin_cnt;
  logic [31:0]        run_max;
  logic [3:0]         run_idx;
  logic [35:0]        run_energy;

  logic signed [31:0] real_ext;
  logic signed [31:0] imag_ext;
  logic signed [31:0] sq_real;
  logic signed [31:0] sq_imag;
  logic [31:0]        mag;
  logic               accept;
  logic               first_bin;
  logic               last_bin;
  logic               new_peak;
  logic [31:0]        peak_mag;
  logic [3:0]         peak_bin;
  logic [35:0]        energy_sum;

  // Each square is at most 2^30, so the sum of two always fits 32 bits unsigned.
  assign real_ext = {{16{in_real[15]}}, in_real};
  assign imag_ext = {{16{in_imag[15]}}, in_imag};
  assign sq_real  = real_ext * real_ext;
  assign sq_imag  = imag_ext * imag_ext;
  assign mag      = $unsigned(sq_real) + $unsigned(sq_imag);

  // Only the final bin of a frame has to wait for the result register to drain.
  assign first_bin = (bin_cnt == 4'd0);
  assign last_bin  = (bin_cnt == LAST_BIN);
  assign in_stall  = out_push & out_stall & last_bin;
  assign accept    = in_push & ~in_stall;

  // Strict compare keeps the lowest index on ties; bin 0 always seeds the frame.
  assign new_peak   = first_bin | (mag > run_max);
  assign peak_mag   = new_peak ? mag : run_max;
  assign peak_bin   = new_peak ? bin_cnt : run_idx;
  assign energy_sum = (first_bin ? 36'd0 : run_energy) + {4'd0, mag};

  // NOTE: every state register uses non-blocking assignment so all flops sample
  // pre-edge values together, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt    <= 4'd0;
      run_max    <= 32'd0;
      run_idx    <= 4'd0;
      run_energy <= 36'd0;
    end else if (accept) begin
      bin_cnt    <= bin_cnt + 4'd1;
      run_max    <= peak_mag;
      run_idx    <= peak_bin;
      run_energy <= energy_sum;
    end
  end

  // Result register: a new frame result may overwrite one transferring on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_push   <= 1'b0;
      out_bin    <= 4'd0;
      out_mag    <= 32'd0;
      out_energy <= 36'd0;
    end else if (accept && last_bin) begin
      out_push   <= 1'b1;
      out_bin    <= peak_bin;
      out_mag    <= peak_mag;
      out_energy <= energy_sum;
    end else if (!out_stall) begin
      out_push   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: frame-level reference results in a queue,
// a cycle-level handshake model, and directed literal checks.
module tb_fft_peak_detect;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_push = 1'b0;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;
  logic               out_stall = 1'b1;
  logic               in_stall;
  logic               out_push;
  logic [3:0]         out_bin;
  logic [31:0]        out_mag;
  logic [35:0]        out_energy;

  fft_peak_detect #(.FRAME_LEN(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_push    (in_push),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .in_stall   (in_stall),
    .out_push   (out_push),
    .out_bin    (out_bin),
    .out_mag    (out_mag),
    .out_energy (out_energy),
    .out_stall  (out_stall)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bin;
    logic [31:0] mag;
    logic [35:0] energy;
  } result_t;

  result_t            exp_q[$];
  logic signed [15:0] fr_re[16];
  logic signed [15:0] fr_im[16];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  bit                 rand_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result of the frame held in fr_re/fr_im, straight from the arithmetic definition.
  function automatic result_t frame_result();
    result_t r;
    longint  m;
    r.bin = 0; r.mag = 0; r.energy = 0;
    for (int i = 0; i < 16; i++) begin
      m = longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
      r.energy += 36'(m);
      if (i == 0 || m > longint'(r.mag)) begin
        r.mag = 32'(m);
        r.bin = 4'(i);
      end
    end
    return r;
  endfunction

  // Handshake model: bins accepted in the current frame and whether a result is waiting.
  int m_cnt   = 0;
  bit m_valid = 0;
  bit m_any   = 0;

  initial forever begin
    bit acc;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_cnt = 0; m_valid = 0; m_any = 0;
      exp_q.delete();
    end else begin
      acc = in_push && !(m_valid && out_stall && m_cnt == 15);
      if (m_valid && !out_stall) begin
        m_valid = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (acc) begin
        if (m_cnt == 15) begin
          m_valid = 1;
          m_any   = 1;
        end
        m_cnt = (m_cnt + 1) % 16;
      end
    end
  end

  // Compare process: every falling edge, outputs against the model and the expected-result queue.
  logic [3:0]  p_bin;
  logic [31:0] p_mag;
  logic [35:0] p_energy;
  bit          p_hold = 0;

  initial forever begin
    bit exp_stall;
    @(negedge clk);
    if (!reset) begin
      check("rst_out_push", 64'(out_push), 64'(0));
      check("rst_out_bin", 64'(out_bin), 64'(0));
      check("rst_out_mag", 64'(out_mag), 64'(0));
      check("rst_out_energy", 64'(out_energy), 64'(0));
      check("rst_in_stall", 64'(in_stall), 64'(0));
      p_hold = 0;
    end else begin
      exp_stall = m_valid && out_stall && m_cnt == 15;
      check("in_stall", 64'(in_stall), 64'(exp_stall));
      check("out_push", 64'(out_push), 64'(m_valid));
      if (m_valid) begin
        check("exp_available", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          check("out_bin", 64'(out_bin), 64'(exp_q[0].bin));
          check("out_mag", 64'(out_mag), 64'(exp_q[0].mag));
          check("out_energy", 64'(out_energy), 64'(exp_q[0].energy));
        end
      end else if (!m_any) begin
        check("idle_out_bin", 64'(out_bin), 64'(0));
        check("idle_out_mag", 64'(out_mag), 64'(0));
        check("idle_out_energy", 64'(out_energy), 64'(0));
      end
      if (p_hold) begin
        check("hold_push", 64'(out_push), 64'(1));
        check("hold_bin", 64'(out_bin), 64'(p_bin));
        check("hold_mag", 64'(out_mag), 64'(p_mag));
        check("hold_energy", 64'(out_energy), 64'(p_energy));
      end
      p_hold   = out_push && out_stall;
      p_bin    = out_bin;
      p_mag    = out_mag;
      p_energy = out_energy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_push = 1'b0;
    if (rand_stall) out_stall = 1'($urandom_range(0, 1));
    step();
  endtask

  // Presents bin i until accepted; out_stall is forced low after release_after stalled cycles.
  task automatic push_bin(input int i, input int release_after, output int stalls);
    in_push = 1'b1;
    in_real = fr_re[i];
    in_imag = fr_im[i];
    stalls  = 0;
    forever begin
      if (rand_stall) out_stall = 1'($urandom_range(0, 1));
      if (stalls >= release_after) out_stall = 1'b0;
      @(negedge clk);
      if (!in_stall) begin
        step();
        break;
      end
      stalls++;
      step();
    end
    in_push = 1'b0;
  endtask

  task automatic push_frame(input int n, input int release_after, output int total_stalls);
    int s;
    total_stalls = 0;
    if (n == 16) exp_q.push_back(frame_result());
    for (int i = 0; i < n; i++) begin
      push_bin(i, release_after, s);
      total_stalls += s;
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  initial begin
    result_t r;
    int      st;

    // Reset with out_stall high: outputs and in_stall must all be zero.
    repeat (3) step();
    reset = 1'b1;
    out_stall = 1'b0;
    step();

    // Single strong bin at index 5.
    clear_frame();
    fr_re[5] = 16'sd32767;
    r = frame_result();
    check("model_t1_bin", 64'(r.bin), 64'(5));
    check("model_t1_mag", 64'(r.mag), 64'h3FFF0001);
    push_frame(16, 1000, st);
    check("t1_push", 64'(out_push), 64'(1));
    check("t1_bin", 64'(out_bin), 64'(5));
    check("t1_mag", 64'(out_mag), 64'h3FFF0001);
    check("t1_energy", 64'(out_energy), 64'h03FFF0001);
    step();
    check("t1_push_clear", 64'(out_push), 64'(0));

    // All bins equal: lowest index wins the tie.
    for (int i = 0; i < 16; i++) begin
      fr_re[i] = 16'sd2047;
      fr_im[i] = 16'sd0;
    end
    r = frame_result();
    check("model_t2_energy", 64'(r.energy), 64'd67043344);
    push_frame(16, 1000, st);
    check("t2_bin", 64'(out_bin), 64'(0));
    check("t2_mag", 64'(out_mag), 64'd4190209);
    check("t2_energy", 64'(out_energy), 64'd67043344);
    step();

    // Most negative corner on the last bin.
    clear_frame();
    fr_re[15] = 16'sh8000;
    fr_im[15] = 16'sh8000;
    push_frame(16, 1000, st);
    check("t3_bin", 64'(out_bin), 64'(15));
    check("t3_mag", 64'(out_mag), 64'h80000000);
    check("t3_energy", 64'(out_energy), 64'h080000000);
    step();

    // Back-to-back frames under downstream backpressure.
    out_stall = 1'b1;
    clear_frame();
    fr_re[2] = 16'sd300;
    fr_im[2] = -16'sd400;
    push_frame(16, 1000, st);
    check("t4a_stalls", 64'(st), 64'(0));
    step();
    step();
    check("t4a_held_push", 64'(out_push), 64'(1));
    check("t4a_held_bin", 64'(out_bin), 64'(2));
    check("t4a_held_mag", 64'(out_mag), 64'd250000);
    clear_frame();
    fr_re[0]  = 16'sd1;
    fr_im[0]  = 16'sd1;
    fr_re[11] = -16'sd5;
    fr_im[11] = 16'sd7;
    push_frame(16, 4, st);
    check("t4b_stalls", 64'(st), 64'(4));
    check("t4b_push", 64'(out_push), 64'(1));
    check("t4b_bin", 64'(out_bin), 64'(11));
    check("t4b_mag", 64'(out_mag), 64'd74);
    check("t4b_energy", 64'(out_energy), 64'd76);
    step();
    check("t4b_push_clear", 64'(out_push), 64'(0));

    // Reset mid-frame with a result still pending.
    out_stall = 1'b1;
    clear_frame();
    fr_re[1] = 16'sd10;
    push_frame(16, 1000, st);
    clear_frame();
    fr_re[3] = 16'sd1000;
    push_frame(7, 1000, st);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    out_stall = 1'b0;
    step();
    clear_frame();
    fr_im[9] = 16'sd100;
    push_frame(16, 1000, st);
    check("t5_push", 64'(out_push), 64'(1));
    check("t5_bin", 64'(out_bin), 64'(9));
    check("t5_mag", 64'(out_mag), 64'd10000);
    check("t5_energy", 64'(out_energy), 64'd10000);
    step();
    check("t5_push_clear", 64'(out_push), 64'(0));

    // Random frames with randomly toggling downstream backpressure.
    rand_stall = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) begin
        fr_re[i] = 16'($urandom);
        fr_im[i] = 16'($urandom);
      end
      if (f == 3) fr_re[6] = fr_re[2];
      if (f == 3) fr_im[6] = fr_im[2];
      push_frame(16, 8, st);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    rand_stall = 0;
    out_stall = 1'b0;
    repeat (20) idle_cycle();
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_push", 64'(out_push), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning FFT bins per frame; the only supported value is 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets).
REQ-004 SHALL have port in_push, input, 1 bit: input bin valid.
REQ-005 SHALL have port in_real, input, 16 bits signed: bin real part.
REQ-006 SHALL have port in_imag, input, 16 bits signed: bin imaginary part.
REQ-007 SHALL have port in_stall, output, 1 bit: the block cannot accept a bin this cycle.
REQ-008 SHALL have port out_push, output, 1 bit: frame result valid.
REQ-009 SHALL have port out_bin, output, 4 bits unsigned: index of the peak bin.
REQ-010 SHALL have port out_mag, output, 32 bits unsigned: peak magnitude squared.
REQ-011 SHALL have port out_energy, output, 36 bits unsigned: sum of magnitude squared over the frame.
REQ-012 SHALL have port out_stall, input, 1 bit: downstream cannot accept a result this cycle.

Function
REQ-013 SHALL accept a bin on a rising edge where in_push=1 and in_stall=0; otherwise inputs are ignored.
REQ-014 SHALL treat accepted bins as consecutive frame indices 0..15, tracked by a 4-bit bin counter that wraps from 15 to 0.
REQ-015 SHALL compute mag = in_real^2 + in_imag^2 exactly, as 32-bit unsigned; (-32768,-32768) gives 0x80000000 with no overflow.
REQ-016 SHALL, at bin index 0, load the running max with mag, the running peak index with 0, and the running energy with mag.
REQ-017 SHALL, at index 1..15, replace max/index only when mag > max (strict), so ties keep the lowest index; it SHALL always add mag to the 36-bit energy.
REQ-018 SHALL, on the edge accepting index 15, load the final peak index, max and energy into the output registers and set out_push=1 (latency: 1 cycle after the last bin).
REQ-019 SHALL transfer a result on an edge where out_push=1 and out_stall=0, then clear out_push on that edge, unless a new result loads on the same edge, in which case out_push stays 1 with the new values.
REQ-020 SHALL hold out_push, out_bin, out_mag and out_energy stable while out_push=1 and out_stall=1.
REQ-021 SHALL drive in_stall = out_push AND out_stall AND (bin counter == 15), combinationally; bins 0..14 of the next frame are accepted while a result waits.
REQ-022 SHALL, when in_stall=1, hold the bin counter and all running state unchanged.
REQ-023 SHALL drive out_bin, out_mag and out_energy to 0 whenever no result has yet been loaded since reset.

Reset
REQ-024 SHALL, while reset=0, force out_push=0, out_bin=0, out_mag=0, out_energy=0, bin counter=0, and running max/index/energy=0, independent of clk.
REQ-025 SHALL, on reset mid-frame, discard the partial frame and the pending result; the first bin accepted after release is index 0.
REQ-026 SHALL, while reset=0, drive in_stall=0, which follows from REQ-021 because out_push=0.

Verification
REQ-027 SHALL pass this test: one frame with only bin 5 = (32767, 0) and out_stall=0 -> one cycle after the 16th bin, out_push=1 for 1 cycle with out_bin=5, out_mag=0x3FFF0001 and out_energy=0x03FFF0001.
REQ-028 SHALL pass this test: all 16 bins = (2047, 0) -> out_bin=0 (tie rule), out_mag=4190209, out_energy=67043344.
REQ-029 SHALL pass this test: only bin 15 = (-32768, -32768) -> out_bin=15, out_mag=0x80000000, out_energy=0x080000000.
REQ-030 SHALL pass this test: two frames back-to-back with out_stall=1 -> result 1 held; in_stall=1 while bin 15 of frame 2 is presented; after out_stall=0, results 1 and 2 are delivered in order with no loss or duplication.
REQ-031 SHALL pass this test: reset=0 asserted after 7 bins of a frame with bin 3 = (1000, 0), then a full frame with only bin 9 = (0, 100) -> the single result is out_bin=9, out_mag=10000, out_energy=10000.
REQ-032 SHALL pass this test: out_stall toggles randomly while 8 random frames are pushed -> results match a reference model, and outputs never change while out_push=1 and out_stall=1.
